// File: rtl/mdio_arbiter.sv
// mdio_arbiter: round-robin sharing of one MDIO engine between two requesters,
// with a per-transaction timeout and a single-cycle completion acknowledge.
module mdio_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 512
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        a_req,
    input  logic        a_wr,
    input  logic [4:0]  a_addr,
    input  logic [15:0] a_wdata,
    output logic        a_ack,
    output logic        a_err,
    output logic [15:0] a_rdata,
    input  logic        b_req,
    input  logic        b_wr,
    input  logic [4:0]  b_addr,
    input  logic [15:0] b_wdata,
    output logic        b_ack,
    output logic        b_err,
    output logic [15:0] b_rdata,
    output logic        busy,
    output logic        grant,
    output logic [4:0]  m_addr,
    output logic [15:0] m_wr_data,
    output logic        m_rd_request,
    output logic        m_wr_request,
    input  logic        m_ready,
    input  logic [15:0] m_rd_data
);

    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [TW-1:0] TLAST = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, BUSY, DONE} state_t;

    state_t        state_q;
    logic          grant_q;
    logic          last_grant_q;
    logic          cmd_wr_q;
    logic          busy_q;
    logic          rd_req_q;
    logic          wr_req_q;
    logic          a_ack_q;
    logic          a_err_q;
    logic          b_ack_q;
    logic          b_err_q;
    logic [15:0]   a_rdata_q;
    logic [15:0]   b_rdata_q;
    logic [15:0]   m_wr_data_q;
    logic [4:0]    m_addr_q;
    logic [TW-1:0] tcnt_q;

    logic          pick_b_d;
    logic          sel_wr_d;
    logic [4:0]    sel_addr_d;
    logic [15:0]   sel_wdata_d;
    logic          timeout_d;
    logic          finish_d;
    logic [15:0]   done_rdata_d;

    // On a tie the port that did not win last time is chosen.
    always_comb begin
        pick_b_d     = b_req & (~a_req | ~last_grant_q);
        sel_wr_d     = pick_b_d ? b_wr    : a_wr;
        sel_addr_d   = pick_b_d ? b_addr  : a_addr;
        sel_wdata_d  = pick_b_d ? b_wdata : a_wdata;
        timeout_d    = (tcnt_q == TLAST);
        finish_d     = timeout_d | ((state_q == BUSY) & m_ready);
        done_rdata_d = timeout_d ? '1 : m_rd_data;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= IDLE;
            grant_q      <= 1'b0;
            last_grant_q <= 1'b1;
            cmd_wr_q     <= 1'b0;
            busy_q       <= 1'b0;
            rd_req_q     <= 1'b0;
            wr_req_q     <= 1'b0;
            a_ack_q      <= 1'b0;
            a_err_q      <= 1'b0;
            b_ack_q      <= 1'b0;
            b_err_q      <= 1'b0;
            a_rdata_q    <= '0;
            b_rdata_q    <= '0;
            m_addr_q     <= '0;
            m_wr_data_q  <= '0;
            tcnt_q       <= '0;
        end else begin
            a_ack_q <= 1'b0;
            b_ack_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (m_ready && (a_req || b_req)) begin
                        grant_q      <= pick_b_d;
                        last_grant_q <= pick_b_d;
                        cmd_wr_q     <= sel_wr_d;
                        m_addr_q     <= sel_addr_d;
                        m_wr_data_q  <= sel_wdata_d;
                        rd_req_q     <= ~sel_wr_d;
                        wr_req_q     <= sel_wr_d;
                        tcnt_q       <= '0;
                        busy_q       <= 1'b1;
                        state_q      <= ISSUE;
                    end
                end
                ISSUE, BUSY: begin
                    if (tcnt_q != '1) begin
                        tcnt_q <= tcnt_q + TW'(1);
                    end
                    // Timeout takes priority over a completion seen in the same cycle.
                    if (finish_d) begin
                        rd_req_q <= 1'b0;
                        wr_req_q <= 1'b0;
                        state_q  <= DONE;
                        if (grant_q) begin
                            b_ack_q <= 1'b1;
                            b_err_q <= timeout_d;
                            if (!cmd_wr_q) begin
                                b_rdata_q <= done_rdata_d;
                            end
                        end else begin
                            a_ack_q <= 1'b1;
                            a_err_q <= timeout_d;
                            if (!cmd_wr_q) begin
                                a_rdata_q <= done_rdata_d;
                            end
                        end
                    end else if ((state_q == ISSUE) && !m_ready) begin
                        rd_req_q <= 1'b0;
                        wr_req_q <= 1'b0;
                        state_q  <= BUSY;
                    end
                end
                DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign a_ack        = a_ack_q;
    assign a_err        = a_err_q;
    assign a_rdata      = a_rdata_q;
    assign b_ack        = b_ack_q;
    assign b_err        = b_err_q;
    assign b_rdata      = b_rdata_q;
    assign busy         = busy_q;
    assign grant        = grant_q;
    assign m_addr       = m_addr_q;
    assign m_wr_data    = m_wr_data_q;
    assign m_rd_request = rd_req_q;
    assign m_wr_request = wr_req_q;

endmodule

// File: tb/tb_mdio_arbiter.sv
// Self-checking bench for mdio_arbiter: behavioural MDIO engine model plus
// command/result scoreboards filled when stimulus is driven.
module tb_mdio_arbiter;

    logic        clock = 1'b0;
    logic        reset;
    logic        a_req, a_wr, b_req, b_wr;
    logic [4:0]  a_addr, b_addr;
    logic [15:0] a_wdata, b_wdata;
    logic        a_ack, a_err, b_ack, b_err;
    logic [15:0] a_rdata, b_rdata;
    logic        busy, grant;
    logic [4:0]  m_addr;
    logic [15:0] m_wr_data;
    logic        m_rd_request, m_wr_request;
    logic        m_ready;
    logic [15:0] m_rd_data;

    always #5 clock = ~clock;

    mdio_arbiter #(.TIMEOUT_CYCLES(512)) dut (
        .clock(clock), .reset(reset),
        .a_req(a_req), .a_wr(a_wr), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_ack(a_ack), .a_err(a_err), .a_rdata(a_rdata),
        .b_req(b_req), .b_wr(b_wr), .b_addr(b_addr), .b_wdata(b_wdata),
        .b_ack(b_ack), .b_err(b_err), .b_rdata(b_rdata),
        .busy(busy), .grant(grant),
        .m_addr(m_addr), .m_wr_data(m_wr_data),
        .m_rd_request(m_rd_request), .m_wr_request(m_wr_request),
        .m_ready(m_ready), .m_rd_data(m_rd_data)
    );

    // Engine model: accepts a request while ready, stays busy eng_lat cycles,
    // returns eng_base ^ addr as read data. eng_stuck freezes it, eng_hold masks ready.
    int unsigned eng_lat;
    logic [15:0] eng_base;
    logic        eng_stuck;
    logic        eng_hold;
    logic        eng_ready_q = 1'b1;
    logic        eng_active  = 1'b0;
    int unsigned eng_cnt     = 0;
    logic [4:0]  eng_addr    = '0;
    logic [15:0] eng_data_q  = '0;

    assign m_ready   = eng_ready_q & ~eng_hold;
    assign m_rd_data = eng_data_q;

    always @(posedge clock) begin
        if (!eng_active) begin
            if (m_ready && (m_rd_request || m_wr_request)) begin
                eng_active  <= 1'b1;
                eng_ready_q <= 1'b0;
                eng_cnt     <= eng_lat;
                eng_addr    <= m_addr;
            end
        end else if (!eng_stuck) begin
            if (eng_cnt <= 1) begin
                eng_active  <= 1'b0;
                eng_ready_q <= 1'b1;
                eng_data_q  <= eng_base ^ {11'd0, eng_addr};
            end else begin
                eng_cnt <= eng_cnt - 1;
            end
        end
    end

    typedef struct packed {
        logic        wr;
        logic [4:0]  addr;
        logic [15:0] wdata;
    } cmd_t;

    typedef struct packed {
        logic        port;
        logic        wr;
        logic        err;
        logic [15:0] rdata;
    } res_t;

    cmd_t cmd_q[$];
    res_t res_q[$];
    int   errors = 0;
    int   checks = 0;

    task automatic monitor();
        logic        prev_req = 1'b0;
        logic [15:0] ea = '0;
        logic [15:0] eb = '0;
        logic        eae = 1'b0;
        logic        ebe = 1'b0;
        cmd_t        c;
        res_t        r;
        forever begin
            @(negedge clock);
            if (reset) begin
                ea = '0; eb = '0; eae = 1'b0; ebe = 1'b0; prev_req = 1'b0;
            end else begin
                if ((m_rd_request | m_wr_request) && !prev_req) begin
                    checks++;
                    if (cmd_q.size() == 0) begin
                        errors++;
                        $display("FAIL cmd_unexpected: rd=%b wr=%b addr=%0d, want no request", m_rd_request, m_wr_request, m_addr);
                    end else begin
                        c = cmd_q.pop_front();
                        if (m_wr_request !== c.wr || m_rd_request !== !c.wr || m_addr !== c.addr
                            || (c.wr && m_wr_data !== c.wdata)) begin
                            errors++;
                            $display("FAIL cmd: rd=%b wr=%b addr=%0d wdata=%h, want wr=%b addr=%0d wdata=%h",
                                     m_rd_request, m_wr_request, m_addr, m_wr_data, c.wr, c.addr, c.wdata);
                        end
                    end
                end
                prev_req = m_rd_request | m_wr_request;
                if (a_ack | b_ack) begin
                    checks++;
                    if (a_ack & b_ack) begin
                        errors++;
                        $display("FAIL ack_both: a_ack=1 b_ack=1, want only one");
                    end else if (res_q.size() == 0) begin
                        errors++;
                        $display("FAIL ack_unexpected: a_ack=%b b_ack=%b, want none", a_ack, b_ack);
                    end else begin
                        r = res_q.pop_front();
                        if (r.port) begin
                            ebe = r.err;
                            if (!r.wr) eb = r.rdata;
                        end else begin
                            eae = r.err;
                            if (!r.wr) ea = r.rdata;
                        end
                        if (b_ack !== r.port || a_err !== eae || b_err !== ebe || a_rdata !== ea || b_rdata !== eb) begin
                            errors++;
                            $display("FAIL result: port=%b a_err=%b b_err=%b a_rdata=%h b_rdata=%h, want port=%b a_err=%b b_err=%b a_rdata=%h b_rdata=%h",
                                     b_ack, a_err, b_err, a_rdata, b_rdata, r.port, eae, ebe, ea, eb);
                        end
                    end
                end
            end
        end
    endtask

    // One solo transaction: queues expectations, raises req, checks the grant
    // edge (when chk), the ack latency (when exp_cycles != 0) and the ack width.
    task automatic run_txn(input logic port, input logic wr, input logic [4:0] addr,
                           input logic [15:0] wdata, input logic exp_err, input logic [15:0] exp_rd,
                           input int unsigned hold, input bit chk, input int unsigned exp_cycles,
                           input int unsigned limit);
        int unsigned cycles = 0;
        logic got = 1'b0;
        logic issued = 1'b0;
        logic prev_ready;
        cmd_t c;
        res_t r;
        c.wr = wr; c.addr = addr; c.wdata = wdata;
        r.port = port; r.wr = wr; r.err = exp_err; r.rdata = exp_rd;
        cmd_q.push_back(c);
        res_q.push_back(r);
        if (port) begin b_wr = wr; b_addr = addr; b_wdata = wdata; b_req = 1'b1; end
        else      begin a_wr = wr; a_addr = addr; a_wdata = wdata; a_req = 1'b1; end
        eng_hold = (hold != 0);
        prev_ready = eng_ready_q & ~eng_hold;
        while (!got && cycles < limit) begin
            @(negedge clock);
            cycles++;
            if (chk && !issued) begin
                if (m_rd_request || m_wr_request) begin
                    issued = 1'b1;
                    checks++;
                    if (prev_ready !== 1'b1 || m_rd_request !== !wr || m_wr_request !== wr
                        || m_addr !== addr || grant !== port || busy !== 1'b1) begin
                        errors++;
                        $display("FAIL issue_p%0d: ready_before=%b rd=%b wr=%b addr=%0d grant=%b busy=%b, want ready_before=1 rd=%b wr=%b addr=%0d grant=%b busy=1",
                                 port, prev_ready, m_rd_request, m_wr_request, m_addr, grant, busy, !wr, wr, addr, port);
                    end
                end else if (prev_ready) begin
                    issued = 1'b1;
                    checks++;
                    errors++;
                    $display("FAIL grant_late_p%0d: no request at cycle %0d, want request one edge after m_ready high", port, cycles);
                end
            end
            if (hold != 0 && cycles == hold) eng_hold = 1'b0;
            prev_ready = eng_ready_q & ~eng_hold;
            got = port ? b_ack : a_ack;
        end
        if (port) b_req = 1'b0; else a_req = 1'b0;
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL ack_timeout_p%0d: no ack in %0d cycles, want ack", port, limit);
        end else if (exp_cycles != 0) begin
            checks++;
            if (cycles != exp_cycles) begin
                errors++;
                $display("FAIL latency_p%0d: ack at cycle %0d, want %0d", port, cycles, exp_cycles);
            end
        end
        @(negedge clock);
        checks++;
        if (a_ack !== 1'b0 || b_ack !== 1'b0) begin
            errors++;
            $display("FAIL ack_width: a_ack=%b b_ack=%b after ack cycle, want 0 0", a_ack, b_ack);
        end
    endtask

    task automatic check_reset_values(input string tag);
        checks++;
        if ({busy, grant, a_ack, b_ack, a_err, b_err, m_rd_request, m_wr_request} !== 8'd0
            || a_rdata !== 16'h0 || b_rdata !== 16'h0 || m_addr !== 5'd0 || m_wr_data !== 16'h0) begin
            errors++;
            $display("FAIL %s: busy=%b grant=%b ack=%b%b err=%b%b req=%b%b a_rdata=%h b_rdata=%h m_addr=%0d m_wr_data=%h, want all 0",
                     tag, busy, grant, a_ack, b_ack, a_err, b_err, m_rd_request, m_wr_request,
                     a_rdata, b_rdata, m_addr, m_wr_data);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        a_req = 1'b0; a_wr = 1'b0; a_addr = '0; a_wdata = '0;
        b_req = 1'b0; b_wr = 1'b0; b_addr = '0; b_wdata = '0;
        eng_lat = 4; eng_base = '0; eng_stuck = 1'b0; eng_hold = 1'b0;
        @(negedge clock);
        @(negedge clock);
        check_reset_values("reset_state");
        reset = 1'b0;
        @(negedge clock);
    endtask

    task automatic test_read_a();
        eng_lat = 130; eng_base = 16'h796C;
        run_txn(1'b0, 1'b0, 5'd1, 16'hBEEF, 1'b0, 16'h796D, 0, 1'b1, 133, 300);
    endtask

    task automatic test_write_b();
        eng_lat = 20; eng_base = 16'h1230;
        run_txn(1'b1, 1'b0, 5'd3, 16'h0000, 1'b0, 16'h1233, 0, 1'b1, 23, 100);
        run_txn(1'b1, 1'b1, 5'd0, 16'h1300, 1'b0, 16'h0000, 0, 1'b1, 23, 100);
        checks++;
        if (grant !== 1'b1 || b_rdata !== 16'h1233 || a_rdata !== 16'h796D) begin
            errors++;
            $display("FAIL write_b_hold: grant=%b b_rdata=%h a_rdata=%h, want grant=1 b_rdata=1233 a_rdata=796d",
                     grant, b_rdata, a_rdata);
        end
    endtask

    task automatic test_round_robin();
        cmd_t c;
        res_t r;
        int unsigned cycles;
        logic got;
        eng_lat = 8; eng_base = 16'h5A00;
        a_wr = 1'b0; a_addr = 5'd2; a_wdata = '0;
        b_wr = 1'b1; b_addr = 5'd5; b_wdata = 16'hCAFE;
        for (int k = 0; k < 4; k++) begin
            c.wr = k[0]; c.addr = k[0] ? 5'd5 : 5'd2; c.wdata = k[0] ? 16'hCAFE : 16'h0000;
            r.port = k[0]; r.wr = k[0]; r.err = 1'b0; r.rdata = k[0] ? 16'h0000 : 16'h5A02;
            cmd_q.push_back(c);
            res_q.push_back(r);
        end
        reset = 1'b1; a_req = 1'b1; b_req = 1'b1;
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
        for (int k = 0; k < 4; k++) begin
            cycles = 0; got = 1'b0;
            while (!got && cycles < 100) begin
                @(negedge clock);
                cycles++;
                got = a_ack | b_ack;
            end
            checks++;
            if (!got) begin
                errors++;
                $display("FAIL rr_ack_timeout: transaction %0d no ack, want ack", k);
            end else if (b_ack !== k[0] || a_ack !== !k[0]) begin
                errors++;
                $display("FAIL rr_order: transaction %0d a_ack=%b b_ack=%b, want b_ack=%b", k, a_ack, b_ack, k[0]);
            end
            if (k > 0) begin
                checks++;
                if (cycles != eng_lat + 4) begin
                    errors++;
                    $display("FAIL rr_spacing: transaction %0d gap %0d, want %0d", k, cycles, eng_lat + 4);
                end
            end
        end
        a_req = 1'b0; b_req = 1'b0;
        repeat (5) @(negedge clock);
        checks++;
        if (busy !== 1'b0 || grant !== 1'b1) begin
            errors++;
            $display("FAIL rr_idle: busy=%b grant=%b, want busy=0 grant=1", busy, grant);
        end
    endtask

    task automatic test_not_ready();
        eng_lat = 12; eng_base = 16'h0440;
        run_txn(1'b0, 1'b1, 5'd4, 16'h55AA, 1'b0, 16'h0000, 20, 1'b1, 35, 100);
    endtask

    task automatic test_timeout();
        eng_stuck = 1'b1; eng_lat = 5;
        run_txn(1'b0, 1'b0, 5'd7, 16'h0000, 1'b1, 16'hFFFF, 0, 1'b1, 513, 700);
        eng_stuck = 1'b0;
        repeat (10) @(negedge clock);
        eng_base = 16'h0F00;
        run_txn(1'b1, 1'b0, 5'd9, 16'h0000, 1'b0, 16'h0F09, 0, 1'b1, 8, 100);
    endtask

    task automatic test_reset_busy();
        cmd_t c;
        eng_lat = 60; eng_base = 16'h2222;
        c.wr = 1'b0; c.addr = 5'd6; c.wdata = '0;
        cmd_q.push_back(c);
        a_wr = 1'b0; a_addr = 5'd6; a_req = 1'b1;
        repeat (10) @(negedge clock);
        checks++;
        if (busy !== 1'b1 || m_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_busy_pre: busy=%b m_ready=%b, want busy=1 m_ready=0", busy, m_ready);
        end
        reset = 1'b1; a_req = 1'b0;
        @(negedge clock);
        check_reset_values("reset_in_busy");
        @(negedge clock);
        reset = 1'b0;
        run_txn(1'b1, 1'b0, 5'd8, 16'h0000, 1'b0, 16'h222A, 0, 1'b1, 0, 200);
        checks++;
        if (cmd_q.size() != 0 || res_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: cmd left=%0d res left=%0d, want 0 0", cmd_q.size(), res_q.size());
        end
    endtask

    initial begin
        reset = 1'b1;
        fork
            monitor();
        join_none
        test_reset();
        test_read_a();
        test_write_b();
        test_round_robin();
        test_not_ready();
        test_timeout();
        test_reset_busy();
        repeat (3) @(negedge clock);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, want completion");
        $fatal(1);
    end

endmodule
